// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_cfg
// Brief  : Oversampling UART receiver with per-frame format capture and a
//          first-word-fall-through FIFO of status-tagged entries.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          baud_tick,
  input  logic                          rx,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_break,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clear_overrun
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_lw = c_aw + 1;
  localparam int c_cw = $clog2(OVERSAMPLE) + 1;
  localparam int c_iw = $clog2(DATA_W) + 1;
  localparam int c_ew = DATA_W + 3;
  localparam logic [c_cw-1:0] c_half_last = c_cw'(OVERSAMPLE / 2 - 1);
  localparam logic [c_cw-1:0] c_bit_last  = c_cw'(OVERSAMPLE - 1);
  localparam logic [c_lw-1:0] c_full      = c_lw'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_sync;
  logic [c_cw-1:0]   r_cnt;
  logic [c_iw-1:0]   r_bit;
  logic [c_iw-1:0]   r_nbits;
  logic [1:0]        r_pmode;
  logic              r_stop2;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_zero;
  logic              r_perr;
  logic              r_ferr;
  logic              r_stop_idx;
  logic              r_brk;

  logic [c_ew-1:0]   r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wptr;
  logic [c_aw-1:0]   r_rptr;
  logic [c_lw-1:0]   r_level;
  logic              r_overrun;

  logic              w_rx;
  logic              w_cnt_hit;
  logic              w_has_par;
  logic              w_is_brk;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic [c_ew-1:0]   w_entry;
  logic [c_ew-1:0]   w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], rx};
  end

  assign w_rx      = (r_sync[0] & r_sync[1]) | (r_sync[1] & r_sync[2]) | (r_sync[0] & r_sync[2]);
  assign w_cnt_hit = (r_cnt == c_bit_last);
  assign w_has_par = (r_pmode == 2'd1) || (r_pmode == 2'd2);
  // Break is decided on the first stop sample only; it also ends the frame.
  assign w_is_brk  = r_zero && !w_rx && !r_stop_idx;
  assign w_push    = enable && baud_tick && (r_state == S_STOP) && !r_brk && w_cnt_hit &&
                     (w_is_brk || !r_stop2 || r_stop_idx);
  assign w_entry   = w_is_brk ? {3'b110, {DATA_W{1'b0}}}
                              : {1'b0, r_ferr | !w_rx, r_perr, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_nbits    <= '0;
      r_pmode    <= '0;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_zero     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_brk      <= 1'b0;
    end else if (!enable) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_brk   <= 1'b0;
    end else if (baud_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_nbits <= c_iw'(cfg_data_bits) + c_iw'(5);
            r_pmode <= cfg_parity;
            r_stop2 <= cfg_stop2;
          end
        end
        S_START: begin
          if (r_cnt == c_half_last) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_DATA;
              r_bit      <= '0;
              r_shift    <= '0;
              r_par      <= 1'b0;
              r_zero     <= 1'b1;
              r_perr     <= 1'b0;
              r_ferr     <= 1'b0;
              r_stop_idx <= 1'b0;
              r_brk      <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_hit) begin
            r_cnt                    <= '0;
            r_shift[r_bit[c_iw-2:0]] <= w_rx;
            r_par                    <= r_par ^ w_rx;
            r_zero                   <= r_zero & !w_rx;
            if (r_bit == r_nbits - c_iw'(1)) r_state <= w_has_par ? S_PARITY : S_STOP;
            else                             r_bit   <= r_bit + c_iw'(1);
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        S_PARITY: begin
          if (w_cnt_hit) begin
            r_cnt   <= '0;
            r_perr  <= (r_pmode == 2'd1) ? (r_par ^ w_rx) : !(r_par ^ w_rx);
            r_zero  <= r_zero & !w_rx;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        S_STOP: begin
          if (r_brk) begin
            if (w_rx) r_state <= S_IDLE;
          end else if (w_cnt_hit) begin
            r_cnt <= '0;
            if (w_is_brk) begin
              r_brk <= 1'b1;
            end else if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
              r_ferr     <= !w_rx;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop  = m_valid && m_ready;
  assign w_full = (r_level == c_full);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else if (!enable) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + c_aw'(1);
      if (w_pop) r_rptr <= r_rptr + c_aw'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lw'(1);
        2'b01:   r_level <= r_level - c_lw'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop)             r_overrun <= 1'b1;
      else if (clear_overrun) r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign m_valid      = (r_level != '0);
  assign m_data       = m_valid ? w_head[DATA_W-1:0] : '0;
  assign m_parity_err = m_valid & w_head[DATA_W];
  assign m_frame_err  = m_valid & w_head[DATA_W+1];
  assign m_break      = m_valid & w_head[DATA_W+2];
  assign fifo_level   = r_level;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// tb_uart_rx_cfg: scenario tasks plus randomized frames checked against a
// frame-level model of what each received entry must contain.
module tb_uart_rx_cfg;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TICK_DIV   = 4;
  localparam int BIT        = OVERSAMPLE * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        baud_tick = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic        m_parity_err, m_frame_err, m_break, m_valid;
  logic        m_ready = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic        overrun;
  logic        clear_overrun = 1'b0;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int div = 0;
  logic [DATA_W+2:0] got_q[$];
  logic [DATA_W+2:0] exp_q[$];

  uart_rx_cfg #(.DATA_W(DATA_W), .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .baud_tick(baud_tick), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    div = (div == TICK_DIV - 1) ? 0 : div + 1;
    baud_tick = (div == 0);
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back({m_break, m_frame_err, m_parity_err, m_data});
      pops++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Entry the receiver must produce for a frame, from the line-format rules.
  function automatic logic [DATA_W+2:0] model(input logic [7:0] d, input int nb, input int pm,
                                              input logic pbit, input logic s1, input logic s2,
                                              input logic two);
    int ones;
    logic [7:0] dm;
    logic has_par, perr, ferr;
    dm = d & 8'((1 << nb) - 1);
    has_par = (pm == 1) || (pm == 2);
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(dm[i]);
    if (dm == 8'h00 && !(has_par && pbit) && !s1) return {3'b110, 8'h00};
    perr = (pm == 1) ? (((ones + int'(pbit)) % 2) == 1) :
           (pm == 2) ? (((ones + int'(pbit)) % 2) == 0) : 1'b0;
    ferr = !s1 || (two && !s2);
    return {1'b0, ferr, perr, dm};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic pbit, input logic s1, input logic s2, input logic two);
    rx = 1'b0; hold(BIT);
    for (int i = 0; i < nb; i++) begin rx = d[i]; hold(BIT); end
    if (has_par) begin rx = pbit; hold(BIT); end
    rx = s1; hold(BIT);
    if (two) begin rx = s2; hold(BIT); end
    rx = 1'b1; hold(2 * BIT);
  endtask

  task automatic set_8n1();
    cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hold(3);
    checks++;
    if ({m_valid, m_data, m_parity_err, m_frame_err, m_break, fifo_level, overrun} !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b data=%h lvl=%0d ovr=%b, required all 0",
                         m_valid, m_data, fifo_level, overrun);
    end
    rst_n = 1'b1; enable = 1'b1; hold(2 * BIT);
    checks++;
    if (m_valid !== 1'b0 || fifo_level !== '0) begin
      errors++; $display("FAIL reset_idle: got valid=%b lvl=%0d, required 0/0", m_valid, fifo_level);
    end
  endtask

  task automatic test_basic();
    set_8n1(); m_ready = 1'b1; got_q.delete(); pops = 0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL basic_pulses: got %0d, required 1", pops); end
    checks++;
    if (got_q.size() == 0 || got_q[0] !== {3'b000, 8'hA5}) begin
      errors++; $display("FAIL basic_entry: got %h, required %h",
                         (got_q.size() > 0) ? got_q[0] : 11'h7FF, {3'b000, 8'hA5});
    end
  endtask

  task automatic test_parity();
    cfg_data_bits = 2'd2; cfg_parity = 2'd1; cfg_stop2 = 1'b1; m_ready = 1'b1; got_q.delete();
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL parity_count: got %0d, required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {3'b001, 8'h41}) begin
        errors++; $display("FAIL parity_bad: got %h, required %h", got_q[0], {3'b001, 8'h41});
      end
      checks++;
      if (got_q[1] !== {3'b000, 8'h41}) begin
        errors++; $display("FAIL parity_good: got %h, required %h", got_q[1], {3'b000, 8'h41});
      end
    end
  endtask

  task automatic test_frame_break();
    set_8n1(); m_ready = 1'b1; got_q.delete();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'b010, 8'h3C}) begin
      errors++; $display("FAIL frame_err: got n=%0d first=%h, required n=1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 11'h7FF, {3'b010, 8'h3C});
    end
    got_q.delete();
    rx = 1'b0; hold(20 * BIT);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL break_low_count: got %0d, required 1", got_q.size());
    end
    rx = 1'b1; hold(3 * BIT);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'b110, 8'h00}) begin
      errors++; $display("FAIL break_entry: got n=%0d first=%h, required n=1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 11'h7FF, {3'b110, 8'h00});
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    set_8n1(); m_ready = 1'b0; got_q.delete();
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovr_level: got %0d, required 4", fifo_level); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b, required 1", overrun); end
    hold(10);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      errors++; $display("FAIL ovr_head_stable: got valid=%b data=%h, required 1/01", m_valid, m_data);
    end
    m_ready = 1'b1; hold(10);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL ovr_drain_count: got %0d, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== {3'b000, 8'(i + 1)}) begin
          errors++; $display("FAIL ovr_drain_order[%0d]: got %h, required %h", i, got_q[i], {3'b000, 8'(i + 1)});
        end
      end
    end
    checks++;
    if (overrun !== 1'b1 || fifo_level !== '0) begin
      errors++; $display("FAIL ovr_sticky: got ovr=%b lvl=%0d, required 1/0", overrun, fifo_level);
    end
    clear_overrun = 1'b1; hold(1); clear_overrun = 1'b0; hold(1);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, required 0", overrun); end
  endtask

  task automatic test_glitch();
    set_8n1(); m_ready = 1'b1; got_q.delete();
    rx = 1'b0; hold(TICK_DIV); rx = 1'b1; hold(2 * BIT);
    checks++;
    if (got_q.size() != 0 || fifo_level !== '0) begin
      errors++; $display("FAIL glitch_push: got n=%0d lvl=%0d, required 0/0", got_q.size(), fifo_level);
    end
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'b000, 8'hC3}) begin
      errors++; $display("FAIL glitch_after: got n=%0d, required one C3 entry", got_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    set_8n1(); m_ready = 1'b0; got_q.delete();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    d = 8'h96;
    rx = 1'b0; hold(BIT);
    for (int i = 0; i < 3; i++) begin rx = d[i]; hold(BIT); end
    rx = d[3]; hold(BIT / 2);
    rst_n = 1'b0; rx = 1'b1; #1;
    checks++;
    if ({m_valid, m_data, m_parity_err, m_frame_err, m_break, fifo_level, overrun} !== '0) begin
      errors++; $display("FAIL rst_mid_async: got valid=%b data=%h lvl=%0d, required all 0",
                         m_valid, m_data, fifo_level);
    end
    hold(3); rst_n = 1'b1; hold(12 * BIT);
    checks++;
    if (fifo_level !== '0) begin errors++; $display("FAIL rst_mid_partial: got lvl=%0d, required 0", fifo_level); end
    m_ready = 1'b1;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {3'b000, 8'h5A}) begin
      errors++; $display("FAIL rst_mid_next: got n=%0d first=%h, required n=1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : 11'h7FF, {3'b000, 8'h5A});
    end
  endtask

  task automatic test_enable();
    set_8n1(); m_ready = 1'b0; got_q.delete();
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 3'd1) begin errors++; $display("FAIL en_fill: got %0d, required 1", fifo_level); end
    enable = 1'b0; hold(2);
    checks++;
    if (fifo_level !== '0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL en_flush: got lvl=%0d valid=%b, required 0/0", fifo_level, m_valid);
    end
    enable = 1'b1; hold(2);
  endtask

  task automatic test_random();
    int cdb, pm, nb;
    logic two, pbit, s1, s2, has_par;
    logic [7:0] d;
    m_ready = 1'b1; got_q.delete(); exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      cdb = $urandom_range(0, 3); pm = $urandom_range(0, 3); nb = 5 + cdb;
      two = 1'($urandom_range(0, 1)); pbit = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0); s2 = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      if (!s1 && (d & 8'((1 << nb) - 1)) == 8'h00) d = 8'h01;
      has_par = (pm == 1) || (pm == 2);
      cfg_data_bits = 2'(cdb); cfg_parity = 2'(pm); cfg_stop2 = two;
      exp_q.push_back(model(d, nb, pm, pbit, s1, s2, two));
      send_frame(d, nb, has_par, pbit, s1, s2, two);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_entry[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_break();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
